// File: rtl/uart_rx_if.sv
// Serial-side and consumer-side signals of the UART receiver.
// The receiver uses the slave modport; the consumer/line driver uses master.
interface uart_rx_if;
  logic       rx;
  logic       ack;
  logic [7:0] readdata;
  logic       valid;
  logic       frame_error;
  logic       overrun;

  modport slave (
    input  rx,
    input  ack,
    output readdata,
    output valid,
    output frame_error,
    output overrun
  );

  modport master (
    output rx,
    output ack,
    input  readdata,
    input  valid,
    input  frame_error,
    input  overrun
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, samples mid-bit and holds each byte
// behind a valid/ack handshake, flagging framing errors and overruns.
module uart_rx #(
  parameter logic [15:0] clock_bit = 16'd9
) (
  input  logic      clock,
  input  logic      resetn,
  uart_rx_if.slave  bus
);

  localparam logic [15:0] HALF_BIT = clock_bit >> 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] counter_q, counter_d;
  logic [2:0]  index_q, index_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  readdata_q, readdata_d;
  logic        valid_q, valid_d;
  logic        frameError_q, frameError_d;
  logic        overrun_q, overrun_d;
  logic        rxMeta_q, rxSync_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      index_q      <= '0;
      shift_q      <= '0;
      readdata_q   <= '0;
      valid_q      <= 1'b0;
      frameError_q <= 1'b0;
      overrun_q    <= 1'b0;
      rxMeta_q     <= 1'b1;
      rxSync_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      index_q      <= index_d;
      shift_q      <= shift_d;
      readdata_q   <= readdata_d;
      valid_q      <= valid_d;
      frameError_q <= frameError_d;
      overrun_q    <= overrun_d;
      rxMeta_q     <= bus.rx;
      rxSync_q     <= rxMeta_q;
    end
  end

  // A completing frame is applied after the ack clear so it wins when both coincide.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    index_d      = index_q;
    shift_d      = shift_q;
    readdata_d   = readdata_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;
    frameError_d = 1'b0;

    if (bus.ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        counter_d = '0;
        index_d   = '0;
        if (!rxSync_q) state_d = START;
      end
      START: begin
        if (counter_q < HALF_BIT) begin
          counter_d = counter_q + 16'd1;
        end else if (!rxSync_q) begin
          counter_d = '0;
          state_d   = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (counter_q < clock_bit) begin
          counter_d = counter_q + 16'd1;
        end else begin
          counter_d        = '0;
          shift_d[index_q] = rxSync_q;
          if (index_q < 3'd7) index_d = index_q + 3'd1;
          else                state_d = STOP;
        end
      end
      STOP: begin
        if (counter_q < clock_bit) begin
          counter_d = counter_q + 16'd1;
        end else if (rxSync_q) begin
          readdata_d = shift_q;
          valid_d    = 1'b1;
          if (valid_q && !bus.ack) overrun_d = 1'b1;
          state_d    = IDLE;
        end else begin
          frameError_d = 1'b1;
          state_d      = BREAK;
        end
      end
      // Hold off until the line returns high so a stuck-low line cannot retrigger.
      BREAK: begin
        if (rxSync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.readdata    = readdata_q;
  assign bus.valid       = valid_q;
  assign bus.frame_error = frameError_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives 8N1 waveforms on rx and compares
// the handshake outputs against a frame-level reference model.
module tb_uart_rx;

  localparam logic [15:0] CB  = 16'd9;
  localparam int          BIT = int'(CB) + 1;
  localparam int          H   = int'(CB) / 2;
  // Edges from driving the start bit to the stop-sample edge: two sync flops,
  // the IDLE detection edge, then h+1 plus nine bit periods.
  localparam int          LAT = 3 + H + 1 + 9 * BIT;

  logic clock = 1'b0;
  logic resetn;

  uart_rx_if bus ();

  uart_rx #(.clock_bit(CB)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int assertCount = 0;
  int failCount   = 0;

  byte unsigned rxBytes[$];
  int   feCycles   = 0;
  int   feRises    = 0;
  int   validRises = 0;
  logic validPrev  = 1'b0;
  logic fePrev     = 1'b0;
  logic validTrace [0:127];

  // Passive monitor on the falling edge, away from the DUT update edge.
  always @(negedge clock) begin
    if (bus.frame_error === 1'b1) begin
      feCycles++;
      if (!fePrev) feRises++;
    end
    if (bus.valid === 1'b1 && !validPrev) begin
      validRises++;
      rxBytes.push_back(bus.readdata);
    end
    validPrev = (bus.valid === 1'b1);
    fePrev    = (bus.frame_error === 1'b1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clearMonitor;
    rxBytes.delete();
    feCycles   = 0;
    feRises    = 0;
    validRises = 0;
  endtask

  function automatic logic lineLevel(input byte unsigned b, input int j, input logic stopLvl);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    return stopLvl;
  endfunction

  task automatic pulseAck;
    bus.ack = 1'b1;
    tick;
    bus.ack = 1'b0;
    tick;
  endtask

  // Drives one whole frame; ackTick>=0 raises ack for exactly that tick, otherwise ack is left alone.
  task automatic applyStimulus(input byte unsigned b, input logic stopLvl, input int ackTick);
    for (int t = 0; t < 10 * BIT; t++) begin
      bus.rx = lineLevel(b, t / BIT, stopLvl);
      if (ackTick >= 0) bus.ack = (t == ackTick);
      tick;
      validTrace[t] = bus.valid;
    end
    if (ackTick >= 0) bus.ack = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    bus.rx = 1'b1;
    bus.ack = 1'b0;
    repeat (3) tick;
    assertCount++;
    if (bus.readdata !== 8'h00) begin
      failCount++;
      $display("[TB] FAIL reset_readdata: got %h expected 00", bus.readdata);
    end
    assertCount++;
    if ({bus.valid, bus.frame_error, bus.overrun} !== 3'b000) begin
      failCount++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {bus.valid, bus.frame_error, bus.overrun});
    end
    resetn = 1'b1;
    tick;
  endtask

  task automatic test_loopback;
    $display("[TB] loopback");
    clearMonitor();
    applyStimulus(8'hA5, 1'b1, -1);
    repeat (5) tick;
    assertCount++;
    if (validTrace[LAT-2] !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL loopback_early_valid: got %b expected 0", validTrace[LAT-2]);
    end
    assertCount++;
    if (validTrace[LAT-1] !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL loopback_valid_latency: got %b expected 1", validTrace[LAT-1]);
    end
    assertCount++;
    if (bus.readdata !== 8'hA5) begin
      failCount++;
      $display("[TB] FAIL loopback_data: got %h expected a5", bus.readdata);
    end
    assertCount++;
    if (feRises != 0 || bus.overrun !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL loopback_errors: got fe=%0d ovr=%b expected fe=0 ovr=0", feRises, bus.overrun);
    end
    pulseAck();
  endtask

  task automatic test_back_to_back;
    byte unsigned expected[3];
    expected[0] = 8'h00;
    expected[1] = 8'hFF;
    expected[2] = 8'h3C;
    $display("[TB] back_to_back");
    clearMonitor();
    fork
      begin
        for (int i = 0; i < 3; i++) applyStimulus(expected[i], 1'b1, -1);
      end
      begin
        for (int c = 0; c < 30 * BIT + 20; c++) begin
          @(posedge clock);
          #1;
          bus.ack = (bus.valid === 1'b1) && !bus.ack;
        end
      end
    join
    bus.ack = 1'b0;
    tick;
    assertCount++;
    if (validRises != 3) begin
      failCount++;
      $display("[TB] FAIL b2b_count: got %0d expected 3", validRises);
    end
    for (int i = 0; i < 3; i++) begin
      assertCount++;
      if (i >= rxBytes.size()) begin
        failCount++;
        $display("[TB] FAIL b2b_byte%0d: got none expected %h", i, expected[i]);
      end else if (rxBytes[i] !== expected[i]) begin
        failCount++;
        $display("[TB] FAIL b2b_byte%0d: got %h expected %h", i, rxBytes[i], expected[i]);
      end
    end
    assertCount++;
    if (feRises != 0 || bus.overrun !== 1'b0 || bus.valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_flags: got fe=%0d ovr=%b valid=%b expected 0 0 0", feRises, bus.overrun, bus.valid);
    end
  endtask

  task automatic test_glitch;
    int len;
    $display("[TB] glitch");
    clearMonitor();
    for (int g = 0; g < 4; g++) begin
      len = (g == 0) ? 3 : int'($urandom_range(1, H + 1));
      bus.rx = 1'b0;
      repeat (len) tick;
      bus.rx = 1'b1;
      repeat (2 * BIT) tick;
      assertCount++;
      if (validRises != 0 || feRises != 0 || bus.valid !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL glitch_len%0d: got valid=%0d fe=%0d expected 0 0", len, validRises, feRises);
      end
    end
  endtask

  task automatic test_frame_error;
    $display("[TB] frame_error");
    clearMonitor();
    applyStimulus(8'h55, 1'b0, -1);
    bus.rx = 1'b0;
    repeat (150) tick;
    assertCount++;
    if (feRises != 1 || feCycles != 1) begin
      failCount++;
      $display("[TB] FAIL fe_pulse: got rises=%0d cycles=%0d expected 1 1", feRises, feCycles);
    end
    assertCount++;
    if (validRises != 0 || bus.valid !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL fe_valid: got rises=%0d valid=%b expected 0 0", validRises, bus.valid);
    end
    bus.rx = 1'b1;
    repeat (2 * BIT) tick;
    applyStimulus(8'h99, 1'b1, -1);
    tick;
    assertCount++;
    if (bus.readdata !== 8'h99 || bus.valid !== 1'b1 || feRises != 1) begin
      failCount++;
      $display("[TB] FAIL fe_recover: got data=%h valid=%b fe=%0d expected 99 1 1", bus.readdata, bus.valid, feRises);
    end
    pulseAck();
  endtask

  task automatic test_overrun;
    $display("[TB] overrun");
    applyStimulus(8'h12, 1'b1, -1);
    applyStimulus(8'h34, 1'b1, -1);
    tick;
    assertCount++;
    if (bus.readdata !== 8'h34 || bus.valid !== 1'b1 || bus.overrun !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL overrun_set: got data=%h valid=%b ovr=%b expected 34 1 1", bus.readdata, bus.valid, bus.overrun);
    end
    pulseAck();
    assertCount++;
    if (bus.valid !== 1'b0 || bus.overrun !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL overrun_clear: got valid=%b ovr=%b expected 0 0", bus.valid, bus.overrun);
    end
    applyStimulus(8'h56, 1'b1, -1);
    applyStimulus(8'h78, 1'b1, LAT - 1);
    tick;
    assertCount++;
    if (bus.readdata !== 8'h78 || bus.valid !== 1'b1 || bus.overrun !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL ack_same_cycle: got data=%h valid=%b ovr=%b expected 78 1 0", bus.readdata, bus.valid, bus.overrun);
    end
    pulseAck();
  endtask

  task automatic test_reset_mid_frame;
    $display("[TB] reset_mid_frame");
    applyStimulus(8'hE7, 1'b1, -1);
    for (int t = 0; t < 5 * BIT + 5; t++) begin
      bus.rx = lineLevel(8'hC3, t / BIT, 1'b1);
      tick;
    end
    clearMonitor();
    resetn = 1'b0;
    tick;
    assertCount++;
    if ({bus.readdata, bus.valid, bus.frame_error, bus.overrun} !== 11'h0) begin
      failCount++;
      $display("[TB] FAIL midreset_outputs: got data=%h v=%b fe=%b ovr=%b expected all 0",
               bus.readdata, bus.valid, bus.frame_error, bus.overrun);
    end
    resetn = 1'b1;
    bus.rx = 1'b1;
    repeat (3 * BIT) tick;
    assertCount++;
    if (validRises != 0 || feRises != 0) begin
      failCount++;
      $display("[TB] FAIL midreset_abandon: got valid=%0d fe=%0d expected 0 0", validRises, feRises);
    end
    applyStimulus(8'hC3, 1'b1, -1);
    tick;
    assertCount++;
    if (bus.readdata !== 8'hC3 || bus.valid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL midreset_next: got data=%h valid=%b expected c3 1", bus.readdata, bus.valid);
    end
    pulseAck();
  endtask

  task automatic test_random;
    logic [7:0]   mData;
    logic         mValid;
    logic         mOverrun;
    byte unsigned b;
    int           len;
    $display("[TB] random");
    mData    = bus.readdata;
    mValid   = 1'b0;
    mOverrun = 1'b0;
    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, 2 * BIT)) tick;
      if ($urandom_range(0, 3) == 0) begin
        len    = int'($urandom_range(1, H + 1));
        bus.rx = 1'b0;
        repeat (len) tick;
        bus.rx = 1'b1;
        repeat (BIT) tick;
      end
      b = 8'($urandom_range(0, 255));
      applyStimulus(b, 1'b1, -1);
      if (mValid) mOverrun = 1'b1;
      mData  = b;
      mValid = 1'b1;
      tick;
      assertCount++;
      if (bus.readdata !== mData || bus.valid !== mValid || bus.overrun !== mOverrun) begin
        failCount++;
        $display("[TB] FAIL random_frame%0d: got data=%h v=%b ovr=%b expected %h %b %b",
                 n, bus.readdata, bus.valid, bus.overrun, mData, mValid, mOverrun);
      end
      if ($urandom_range(0, 1) == 1) begin
        pulseAck();
        mValid   = 1'b0;
        mOverrun = 1'b0;
        assertCount++;
        if (bus.valid !== mValid || bus.overrun !== mOverrun || bus.readdata !== mData) begin
          failCount++;
          $display("[TB] FAIL random_ack%0d: got data=%h v=%b ovr=%b expected %h %b %b",
                   n, bus.readdata, bus.valid, bus.overrun, mData, mValid, mOverrun);
        end
      end
    end
  endtask

  initial begin
    bus.rx  = 1'b1;
    bus.ack = 1'b0;
    resetn  = 1'b0;
    test_reset();
    test_loopback();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receiver half of the RS-232 link: deserialises 8N1 frames from the external rx pin into bytes.
- Sits downstream of the transmit block on the far end of the serial line and consumes its tx waveform.
- Uses the same bit-timing parameter as the transmitter, so matched instances interoperate.
- Holds each received byte in an output register behind a valid/ack handshake, and reports framing errors and overruns.

Parameters:
- clock_bit, 16'd9: bit period minus one, in clock cycles. One bit lasts clock_bit+1 clocks, matching the transmitter. Minimum legal value is 2.

Ports:
- clock  input  1  system clock.
- resetn  input  1  synchronous, active-low reset.
- rx  input  1  external serial input pin; asynchronous; idles high.
- ack  input  1  consumer has taken readdata; clears valid and overrun.
- readdata  output  8  last correctly framed byte, LSB received first.
- valid  output  1  readdata holds an unconsumed byte; level, held until ack.
- frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  sticky; set when a new byte overwrites an unacknowledged one.

Behaviour:
- Reset, sampled on posedge clock while resetn=0:
  - readdata=0, valid=0, frame_error=0, overrun=0.
  - state=IDLE, counter=0, index=0, shift register=0.
  - Both synchroniser flops = 1.
  - Reset mid-frame abandons the frame; no valid and no error is produced for it.
- Synchroniser: rx passes through two flops to give rx_s. All decisions use rx_s only.
- Let h = clock_bit>>1 (integer divide).
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - counter<=0, index<=0.
  - If rx_s=0, go to START; otherwise stay.
- START:
  - If counter<h: counter++.
  - Else (mid start bit): if rx_s=0, counter<=0 and go to DATA; if rx_s=1, treat as glitch and go to IDLE with no output.
- DATA:
  - If counter<clock_bit: counter++.
  - Else: counter<=0, shift[index]<=rx_s.
  - If index<7: index++. Otherwise go to STOP.
- STOP:
  - If counter<clock_bit: counter++.
  - Else, if rx_s=1: readdata<=shift, valid<=1, go to IDLE.
  - Else, if rx_s=0: frame_error<=1 for exactly one cycle, readdata/valid unchanged, go to BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from retriggering frames.
- Sample timing:
  - Let E be the edge at which IDLE sees rx_s=0.
  - Start check at E+h+1.
  - Data bit i is sampled at E+h+1+(i+1)*(clock_bit+1).
  - Stop bit is sampled at E+h+1+9*(clock_bit+1); valid is high from the following cycle.
- Returning to IDLE at mid-stop is intended. The second half of the stop bit is high, so it cannot cause a false start, and back-to-back frames are accepted.
- Handshake:
  - ack=1 with valid=1: valid<=0, overrun<=0.
  - ack with valid=0 has no effect.
  - Completion of a good frame while valid=1 and ack=0: readdata overwritten, valid stays 1, overrun<=1.
  - Completion in the same cycle as ack: readdata<=new byte, valid stays 1, overrun<=0. Completion takes priority over the clear.
- counter is 16 bits. index is 3 bits and never wraps beyond 7 within a frame.
- Unused state encodings go to IDLE.

Test Plan:
- Loopback: drive rx from a transmitter instance with clock_bit=9 and send 8'hA5. Required: valid rises exactly 1 cycle after the stop-sample edge, readdata=8'hA5, frame_error and overrun never assert.
- Back-to-back: transmitter sends 8'h00, 8'hFF, 8'h3C with ack pulsed after each valid. Required: three valid assertions with the correct bytes; no frame lost despite only one idle bit between frames.
- Glitch: rx low for 3 clocks, then high (clock_bit=9, h=4). Required: return to IDLE, no valid, no frame_error.
- Framing error: send 8'h55 with the stop bit forced low, then hold rx low 40 clocks, then release. Required: one frame_error pulse, valid stays 0, no new frame starts until rx is high again.
- Overrun: receive 8'h12 and 8'h34 without ack. Required: readdata=8'h34, valid=1, overrun=1. Then one ack cycle: valid=0, overrun=0.
- Reset mid-frame: assert resetn=0 during DATA bit 4 for one cycle, then send 8'hC3. Required: all outputs 0 after reset; the next frame yields readdata=8'hC3.
